// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared types and default parameters for the FIFO write arbiter and its
// round-robin picker. No ports; imported by rr_picker and fifo_wr_arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int default_num_req   = 4;
  localparam int default_width     = 16;
  localparam int default_max_burst = 4;

endpackage

// File: rtl/rr_picker.sv
// rr_picker
// Combinational round-robin selector. Scans req upward starting at rr_ptr,
// wrapping modulo num_req, and reports the first set index. Usable for any
// shared port (write side or read side of a FIFO).
//
// Ports:
//   req        in  num_req           request vector
//   rr_ptr     in  $clog2(num_req)   index with highest priority this cycle
//   pick_valid out 1                 at least one request bit is set
//   pick_idx   out $clog2(num_req)   chosen index (0 when pick_valid = 0)
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int num_req = default_num_req
) (
  input  logic [num_req-1:0]         req,
  input  logic [$clog2(num_req)-1:0] rr_ptr,
  output logic                       pick_valid,
  output logic [$clog2(num_req)-1:0] pick_idx
);

  localparam int idx_w = $clog2(num_req);

  // Walk the offsets from farthest to nearest so the candidate closest to
  // rr_ptr is the last one written and therefore wins.
  always_comb begin
    int               cand;
    logic [idx_w-1:0] cand_idx;
    cand       = 0;
    cand_idx   = '0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int off = num_req - 1; off >= 0; off--) begin
      cand = int'(rr_ptr) + off;
      if (cand >= num_req) cand = cand - num_req;
      cand_idx = idx_w'(cand);
      if (req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing one synchronous FIFO write port among num_req
// valid/ready producers. A granted producer may push up to max_burst beats,
// forwarded combinationally to the FIFO, and every grant is followed by one
// idle arbitration cycle.
//
// Ports:
//   clk           in  1                 rising-edge clock
//   rst           in  1                 asynchronous active-high reset
//   req_valid     in  num_req           producer i has a beat
//   req_data      in  num_req x width   producer i's beat (unpacked array)
//   req_ready     out num_req           producer i's beat accepted this cycle
//   fifo_full     in  1                 FIFO full flag (registered in FIFO)
//   fifo_write    out 1                 FIFO write strobe
//   fifo_data_in  out width             FIFO write data (0 when not writing)
//   grant_id      out $clog2(num_req)   currently / last granted producer
//   busy          out 1                 high while a grant is held
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int num_req   = default_num_req,
  parameter int width     = default_width,
  parameter int max_burst = default_max_burst
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [num_req-1:0]         req_valid,
  input  logic [width-1:0]           req_data [num_req],
  output logic [num_req-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_write,
  output logic [width-1:0]           fifo_data_in,
  output logic [$clog2(num_req)-1:0] grant_id,
  output logic                       busy
);

  localparam int idx_w = $clog2(num_req);
  localparam int cnt_w = $clog2(max_burst + 1);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(max_burst - 1);
  localparam logic [idx_w-1:0] last_idx  = idx_w'(num_req - 1);

  arb_state_t       state;
  logic [idx_w-1:0] rr_ptr;
  logic [cnt_w-1:0] beat_cnt;

  logic             pick_valid;
  logic [idx_w-1:0] pick_idx;
  logic             granted_valid;
  logic             beat;
  logic             release_grant;

  rr_picker #(.num_req(num_req)) u_picker (
    .req        (req_valid),
    .rr_ptr     (rr_ptr),
    .pick_valid (pick_valid),
    .pick_idx   (pick_idx)
  );

  assign granted_valid = req_valid[grant_id];

  // A beat moves only when the granted producer offers data and the FIFO has
  // room; a full FIFO therefore can never be written.
  assign beat = (state == ARB_GRANT) && granted_valid && !fifo_full;

  // A dropped valid releases even while the FIFO is full (no write happens).
  assign release_grant = (state == ARB_GRANT) &&
                         (!granted_valid || (beat && (beat_cnt == last_beat)));

  always_comb begin
    req_ready = '0;
    if (state == ARB_GRANT) req_ready[grant_id] = !fifo_full;
  end

  assign fifo_write   = beat;
  assign fifo_data_in = beat ? req_data[grant_id] : '0;

  // Arbitration FSM. The pointer advances past the released producer so the
  // next scan starts at its neighbour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            state    <= ARB_GRANT;
            busy     <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (beat) beat_cnt <= beat_cnt + 1'b1;
          if (release_grant) begin
            state  <= ARB_IDLE;
            busy   <= 1'b0;
            rr_ptr <= (grant_id == last_idx) ? '0 : grant_id + 1'b1;
          end
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter: directed scenarios (reset,
// single producer, contention, stall, early drop, overflow) followed by
// randomized producers and FIFO reads, all checked cycle by cycle against a
// behavioural arbiter model and a queue-based FIFO.
module tb_fifo_wr_arbiter;

  localparam int num_req   = 4;
  localparam int width     = 16;
  localparam int max_burst = 4;
  localparam int depth     = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [num_req-1:0] req_valid;
  logic [width-1:0]   req_data [num_req];
  logic [num_req-1:0] req_ready;
  logic               fifo_full;
  logic               fifo_write;
  logic [width-1:0]   fifo_data_in;
  logic [1:0]         grant_id;
  logic               busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.num_req(num_req), .width(width), .max_burst(max_burst)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_write   (fifo_write),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: whether a grant is held, who owns it, how many beats it
  // has moved, and where the next fair scan begins.
  bit m_active;
  int m_owner;
  int m_beats;
  int m_next;
  int grant_log [$];

  // Expected outputs for the current cycle.
  logic [num_req-1:0] e_ready;
  bit                 e_write;
  logic [width-1:0]   e_data;
  bit                 e_busy;
  int                 e_grant;

  // Producer and FIFO environment.
  logic [num_req-1:0] prod_valid;
  logic [11:0]        prod_seq [num_req];
  logic [width-1:0]   fifo_q [$];
  int  rise_pct, keep_pct, drop_pct, read_pct;
  bit  use_fifo;
  bit  force_full;
  int  write_count;

  // Single comparison point: count, and report any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Drive the DUT inputs from the producer and FIFO environment.
  task automatic applyStimulus();
    req_valid = prod_valid;
    for (int i = 0; i < num_req; i++) req_data[i] = {4'(i), prod_seq[i]};
    fifo_full = use_fifo ? (fifo_q.size() >= depth) : force_full;
  endtask

  // What the arbiter should present this cycle, from the grant rules.
  task automatic computeExpected();
    e_ready = '0;
    e_write = 1'b0;
    e_data  = '0;
    e_busy  = m_active;
    e_grant = m_owner;
    if (m_active) begin
      if (!fifo_full) e_ready[m_owner] = 1'b1;
      if (prod_valid[m_owner] && !fifo_full) begin
        e_write = 1'b1;
        e_data  = req_data[m_owner];
      end
    end
  endtask

  // Advance the model, the FIFO and the producers across one clock edge.
  task automatic updateModel();
    if (!m_active) begin
      if (prod_valid != '0) begin
        for (int off = num_req - 1; off >= 0; off--)
          if (prod_valid[(m_next + off) % num_req]) m_owner = (m_next + off) % num_req;
        m_beats  = 0;
        m_active = 1'b1;
        grant_log.push_back(m_owner);
      end
    end else begin
      if (e_write) m_beats++;
      if (!prod_valid[m_owner] || (e_write && m_beats == max_burst)) begin
        m_active = 1'b0;
        m_next   = (m_owner + 1) % num_req;
      end
    end
    if (e_write) begin
      write_count++;
      if (use_fifo) fifo_q.push_back(e_data);
    end
    if (use_fifo && fifo_q.size() > 0 && $urandom_range(99) < read_pct)
      void'(fifo_q.pop_front());
    for (int i = 0; i < num_req; i++) begin
      if (prod_valid[i] && e_ready[i]) begin
        prod_seq[i]++;
        if ($urandom_range(99) >= keep_pct) prod_valid[i] = 1'b0;
      end else if (prod_valid[i]) begin
        if ($urandom_range(99) < drop_pct) prod_valid[i] = 1'b0;
      end else if ($urandom_range(99) < rise_pct) begin
        prod_valid[i] = 1'b1;
      end
    end
  endtask

  // One full cycle: drive at the falling edge, check mid-cycle, update on
  // the rising edge, return at the next falling edge.
  task automatic runCycle();
    applyStimulus();
    #1;
    computeExpected();
    checkOutput("req_ready", req_ready, e_ready);
    checkOutput("fifo_write", fifo_write, e_write);
    checkOutput("fifo_data_in", fifo_data_in, e_data);
    checkOutput("grant_id", grant_id, e_grant);
    checkOutput("busy", busy, e_busy);
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  // Hold reset for one cycle with the given valid pattern, confirm quiet
  // outputs, then clear the model and environment.
  task automatic doReset(input logic [num_req-1:0] valid_pattern);
    rst        = 1'b1;
    prod_valid = valid_pattern;
    for (int i = 0; i < num_req; i++) prod_seq[i] = 12'h0;
    force_full = 1'b0;
    use_fifo   = 1'b0;
    fifo_q.delete();
    applyStimulus();
    #1;
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_fifo_write", fifo_write, 0);
    checkOutput("rst_fifo_data", fifo_data_in, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_grant_id", grant_id, 0);
    m_active    = 1'b0;
    m_owner     = 0;
    m_beats     = 0;
    m_next      = 0;
    write_count = 0;
    grant_log.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scenario sequencing.
  initial begin
    rst = 1'b1;
    rise_pct = 0; keep_pct = 100; drop_pct = 0; read_pct = 0;
    prod_valid = '0;
    @(negedge clk);

    // Reset with every producer requesting, then full contention.
    $display("[TB] contention");
    doReset(4'hF);
    for (int c = 0; c < 20; c++) runCycle();
    checkOutput("contention_writes", write_count, 16);
    checkOutput("contention_len", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      checkOutput("contention_order", grant_log[k], k);

    // Asynchronous reset in the middle of a burst.
    runCycle();
    runCycle();
    applyStimulus();
    #1;
    checkOutput("pre_rst_write", fifo_write, 1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_write", fifo_write, 0);
    checkOutput("midrst_ready", req_ready, 0);
    checkOutput("midrst_data", fifo_data_in, 0);
    checkOutput("midrst_busy", busy, 0);
    @(negedge clk);

    // Single producer 2 with data starting at 0x00A.
    $display("[TB] single producer");
    doReset(4'b0100);
    prod_seq[2] = 12'h00A;
    for (int c = 0; c < 12; c++) runCycle();
    checkOutput("single_writes", write_count, 9);
    checkOutput("single_regrant", (grant_log.size() >= 2) ? grant_log[1] : -1, 2);

    // Producer 1 stalled by a full FIFO for three cycles after beat 2.
    $display("[TB] stall");
    doReset(4'b0010);
    for (int c = 0; c < 3; c++) runCycle();
    force_full = 1'b1;
    for (int c = 0; c < 3; c++) runCycle();
    force_full = 1'b0;
    for (int c = 0; c < 3; c++) runCycle();
    checkOutput("stall_writes", write_count, 4);

    // Producer 1 drops after one beat; 2 and 3 must be served before 1.
    $display("[TB] early drop");
    doReset(4'b1110);
    runCycle();
    runCycle();
    prod_valid[1] = 1'b0;
    runCycle();
    prod_valid[1] = 1'b1;
    for (int c = 0; c < 12; c++) runCycle();
    checkOutput("drop_len", (grant_log.size() >= 4) ? 1 : 0, 1);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      checkOutput("drop_order", grant_log[k], (k == 3) ? 1 : k + 1);

    // Overflow protection: no reads, everyone streaming.
    $display("[TB] overflow");
    doReset(4'hF);
    use_fifo = 1'b1;
    read_pct = 0;
    for (int c = 0; c < 30; c++) runCycle();
    checkOutput("overflow_writes", write_count, depth);

    // Randomized producers and FIFO consumer.
    $display("[TB] random");
    doReset(4'h0);
    use_fifo = 1'b1;
    rise_pct = 30; keep_pct = 60; drop_pct = 3; read_pct = 45;
    for (int c = 0; c < 3000; c++) runCycle();
    read_pct = 85; rise_pct = 60; keep_pct = 85;
    for (int c = 0; c < 2000; c++) runCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
